// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath constants and ALU op encodings used by the register file,
// the ALU and the control decoder.
package legv8_pkg;

    localparam int DATA_WIDTH     = 64;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int XZR_IDX        = 31;

    typedef enum logic [2:0] {
        ALU_SUB    = 3'b001,
        ALU_ADD    = 3'b010,
        ALU_DIV    = 3'b011,
        ALU_MUL    = 3'b100,
        ALU_PASS_A = 3'b101
    } alu_op_e;

endpackage

// File: rtl/legv8_regfile_read_port.sv
// One combinational register-file read mux: XZR masking plus an optional
// same-cycle write-to-read bypass selected by the BYPASS parameter.
module legv8_regfile_read_port
    import legv8_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 31,
    parameter bit BYPASS     = 1'b0
) (
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH],
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic bypass_hit;

    // Bypass is held off during reset so the port shows the stored value being cleared.
    always_comb begin
        bypass_hit = BYPASS && !reset && wr_en
                     && (wr_addr != ZERO_ADDR) && (wr_addr == rd_addr);
    end

    always_comb begin
        rd_data = regs[rd_addr];
        if (bypass_hit) begin
            rd_data = wr_data;
        end
        if (rd_addr == ZERO_ADDR) begin
            rd_data = '0;
        end
    end

endmodule

// File: rtl/legv8_register_file.sv
// 32 x 64-bit LEGv8 register file, X31 hardwired as XZR, two combinational read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to matching reads.
module legv8_register_file
    import legv8_pkg::*;
#(
    parameter int DATA_WIDTH = legv8_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = legv8_pkg::REG_ADDR_WIDTH,
    parameter int ZERO_REG   = legv8_pkg::XZR_IDX
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    output logic [DATA_WIDTH-1:0] rd_data1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data2,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Reset outranks a coincident write; the XZR slot is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (wr_addr != ZERO_ADDR)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    legv8_regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG),
        .BYPASS     (BYPASS)
    ) u_read_port1 (
        .reset   (reset),
        .rd_addr (rd_addr1),
        .regs    (mem),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data1)
    );

    legv8_regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG),
        .BYPASS     (BYPASS)
    ) u_read_port2 (
        .reset   (reset),
        .rd_addr (rd_addr2),
        .regs    (mem),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data2)
    );

endmodule

// File: tb/tb_legv8_register_file.sv
// Directed self-checking bench for legv8_register_file (both REGFILE_BYPASS_EN builds).
module tb_legv8_register_file;
    import legv8_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr1;
    logic [63:0] rd_data1;
    logic [4:0]  rd_addr2;
    logic [63:0] rd_data2;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;

    int checks = 0;
    int errors = 0;

    legv8_register_file #(
        .DATA_WIDTH (64),
        .ADDR_WIDTH (5),
        .ZERO_REG   (31)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr1 (rd_addr1),
        .rd_data1 (rd_data1),
        .rd_addr2 (rd_addr2),
        .rd_data2 (rd_data2),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input int unsigned i);
        logic [7:0] idx;
        idx = 8'(i);
        return {idx, 24'h00C0DE, idx, 24'h00BEEF};
    endfunction

    function automatic logic [63:0] alu_model(input alu_op_e op, input logic [63:0] a,
                                              input logic [63:0] b);
        case (op)
            ALU_ADD:    return a + b;
            ALU_SUB:    return a - b;
            ALU_MUL:    return a * b;
            ALU_PASS_A: return a;
            default:    return '0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wr_en = 1'b0;
        tick();
        tick();
        idle();
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i);
            rd_addr2 = 5'(31 - i);
            #1;
            checks++;
            if (rd_data1 !== 64'd0) begin
                errors++;
                $display("FAIL reset_p1 x%0d got %h want 0", i, rd_data1);
            end
            checks++;
            if (rd_data2 !== 64'd0) begin
                errors++;
                $display("FAIL reset_p2 x%0d got %h want 0", 31 - i, rd_data2);
            end
        end
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h0123_4567_89AB_CDEF;
        tick();
        idle();
        rd_addr1 = 5'd5; rd_addr2 = 5'd5;
        #1;
        checks++;
        if (rd_data1 !== 64'h0123_4567_89AB_CDEF) begin
            errors++;
            $display("FAIL wr_rd_p1 got %h want 0123456789abcdef", rd_data1);
        end
        checks++;
        if (rd_data2 !== 64'h0123_4567_89AB_CDEF) begin
            errors++;
            $display("FAIL wr_rd_p2 got %h want 0123456789abcdef", rd_data2);
        end
    endtask

    task automatic test_zero_reg();
        for (int i = 0; i < 31; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = pat(i);
            tick();
        end
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        rd_addr1 = 5'd31; rd_addr2 = 5'd31;
        #1;
        checks++;
        if (rd_data1 !== 64'd0) begin
            errors++;
            $display("FAIL xzr_same_cycle got %h want 0", rd_data1);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_data1 !== 64'd0) begin
            errors++;
            $display("FAIL xzr_p1 got %h want 0", rd_data1);
        end
        checks++;
        if (rd_data2 !== 64'd0) begin
            errors++;
            $display("FAIL xzr_p2 got %h want 0", rd_data2);
        end
        for (int i = 0; i < 31; i++) begin
            rd_addr1 = 5'(i);
            rd_addr2 = 5'(30 - i);
            #1;
            checks++;
            if (rd_data1 !== pat(i)) begin
                errors++;
                $display("FAIL keep_p1 x%0d got %h want %h", i, rd_data1, pat(i));
            end
            checks++;
            if (rd_data2 !== pat(30 - i)) begin
                errors++;
                $display("FAIL keep_p2 x%0d got %h want %h", 30 - i, rd_data2, pat(30 - i));
            end
        end
    endtask

    task automatic test_write_disable();
        wr_en = 1'b0; wr_addr = 5'd9; wr_data = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        idle();
        rd_addr1 = 5'd9;
        #1;
        checks++;
        if (rd_data1 !== pat(9)) begin
            errors++;
            $display("FAIL wr_en_low got %h want %h", rd_data1, pat(9));
        end
    endtask

    task automatic test_collision();
        logic [63:0] exp_now;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'd9;
        tick();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'd42;
        rd_addr1 = 5'd7; rd_addr2 = 5'd8;
`ifdef REGFILE_BYPASS_EN
        exp_now = 64'd42;
`else
        exp_now = 64'd9;
`endif
        #1;
        checks++;
        if (rd_data1 !== exp_now) begin
            errors++;
            $display("FAIL collide_same got %0d want %0d", rd_data1, exp_now);
        end
        checks++;
        if (rd_data2 !== pat(8)) begin
            errors++;
            $display("FAIL collide_other_port got %h want %h", rd_data2, pat(8));
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_data1 !== 64'd42) begin
            errors++;
            $display("FAIL collide_next got %0d want 42", rd_data1);
        end
    endtask

    task automatic test_reset_priority();
        reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'd100;
        rd_addr1 = 5'd3; rd_addr2 = 5'd7;
        #1;
        checks++;
        if (rd_data1 !== pat(3)) begin
            errors++;
            $display("FAIL rst_no_bypass got %h want %h", rd_data1, pat(3));
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_data1 !== 64'd0) begin
            errors++;
            $display("FAIL rst_wins got %0d want 0", rd_data1);
        end
        checks++;
        if (rd_data2 !== 64'd0) begin
            errors++;
            $display("FAIL rst_clears_x7 got %0d want 0", rd_data2);
        end
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'd100;
        tick();
        idle();
        #1;
        checks++;
        if (rd_data1 !== 64'd100) begin
            errors++;
            $display("FAIL post_rst_write got %0d want 100", rd_data1);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] res;
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 64'd10;
        tick();
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'd3;
        tick();
        idle();
        rd_addr1 = 5'd1; rd_addr2 = 5'd2;
        #1;
        checks++;
        if (rd_data1 !== 64'd10) begin
            errors++;
            $display("FAIL b2b_x1 got %0d want 10", rd_data1);
        end
        checks++;
        if (rd_data2 !== 64'd3) begin
            errors++;
            $display("FAIL b2b_x2 got %0d want 3", rd_data2);
        end
        res = alu_model(ALU_SUB, rd_data1, rd_data2);
        checks++;
        if (res !== 64'd7) begin
            errors++;
            $display("FAIL b2b_sub got %0d want 7", res);
        end
        checks++;
        if ((res == 64'd0) !== 1'b0) begin
            errors++;
            $display("FAIL b2b_zero got %0b want 0", res == 64'd0);
        end
    endtask

    initial begin
        idle();
        rd_addr1 = '0;
        rd_addr2 = '0;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_write_disable();
        test_collision();
        test_reset_priority();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
